uart_cmd_parser: RTL and testbench

// - Sits directly downstream of the UART receive FIFO and upstream of the UART transmit FIFO.
// - Parses ASCII command lines from the host into display registers: seven-segment value, diode bar level, warn flag.
// - Answers each line with a one-byte status: 'K' (accepted) or 'E' (rejected).

---
 rtl/uart_cmd_parser.sv | 122 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns ASCII command lines from the RX FIFO into display registers and answers each with K/E
module uart_cmd_parser #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TO_W           = 26
) (
   input  logic        clk,
   input  logic        key_reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_empty,
   output logic        rd_uart,
   input  logic        tx_full,
   output logic        wr_uart,
   output logic [7:0]  tx_data,
   output logic [15:0] sseg_val,
   output logic [9:0]  bar_level,
   output logic        warn,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, HEX, EOL, FLUSH, ACK} state_t;
   localparam logic [1:0] CMD_S = 2'd0, CMD_L = 2'd1, CMD_W = 2'd2;
   localparam logic [7:0] ST_K = 8'h4B, ST_E = 8'h45;
   state_t          state_q, state_d;
   logic [1:0]      cmd_q, cmd_d;
   logic [15:0]     sr_q, sr_d, sseg_q, sseg_d;
   logic [2:0]      cnt_q, cnt_d, need;
   logic [TO_W-1:0] to_q, to_d;
   logic [7:0]      status_q, status_d;
   logic [9:0]      bar_q, bar_d, therm;
   logic            warn_q, warn_d;
   logic            is_term, is_dig, is_hex, valid, timeout;
   logic [3:0]      nib;
   // state and datapath registers; reset drops any partial frame
   always_ff @(posedge clk or negedge key_reset) begin
      if (!key_reset) begin
         state_q  <= IDLE;
         cmd_q    <= CMD_S;
         sr_q     <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         status_q <= '0;
         sseg_q   <= '0;
         bar_q    <= '0;
         warn_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         status_q <= status_d;
         sseg_q   <= sseg_d;
         bar_q    <= bar_d;
         warn_q   <= warn_d;
      end
   end
   // classify the head byte and judge the value collected so far
   always_comb begin
      is_term = rx_data == 8'h0D || rx_data == 8'h0A;
      is_dig  = rx_data >= "0" && rx_data <= "9";
      is_hex  = is_dig || (rx_data >= "A" && rx_data <= "F") || (rx_data >= "a" && rx_data <= "f");
      nib     = is_dig ? rx_data[3:0] : rx_data[3:0] + 4'd9;
      need    = cmd_q == CMD_S ? 3'd4 : cmd_q == CMD_L ? 3'd2 : 3'd1;
      valid   = cmd_q == CMD_S || (cmd_q == CMD_L ? sr_q[7:0] <= 8'd10 : sr_q[3:0] <= 4'd1);
      therm   = ~(10'h3FF << sr_q[3:0]);
      timeout = rx_empty && to_q == TO_W'(TIMEOUT_CYCLES - 1);
   end
   // next state, frame assembly and the single register write per accepted frame
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      sseg_d   = sseg_q;
      bar_d    = bar_q;
      warn_d   = warn_q;
      to_d     = rx_empty && state_q inside {HEX, EOL, FLUSH} ? to_q + 1'b1 : '0;
      case (state_q)
         IDLE: if (!rx_empty && (rx_data == "S" || rx_data == "L" || rx_data == "W")) begin
            state_d = HEX;
            cmd_d   = rx_data == "S" ? CMD_S : rx_data == "L" ? CMD_L : CMD_W;
            sr_d    = '0;
            cnt_d   = '0;
         end else if (!rx_empty && !is_term) state_d = FLUSH;
         HEX: if (timeout) begin
            state_d  = ACK;
            status_d = ST_E;
         end else if (!rx_empty && is_hex) begin
            sr_d  = {sr_q[11:0], nib};
            cnt_d = cnt_q + 3'd1;
            if (cnt_d == need) state_d = EOL;
         end else if (!rx_empty) state_d = FLUSH;
         EOL: if (timeout) begin
            state_d  = ACK;
            status_d = ST_E;
         end else if (!rx_empty && is_term) begin
            state_d  = ACK;
            status_d = valid ? ST_K : ST_E;
            if (valid && cmd_q == CMD_S) sseg_d = sr_q;
            if (valid && cmd_q == CMD_L) bar_d = therm;
            if (valid && cmd_q == CMD_W) warn_d = sr_q[0];
         end else if (!rx_empty) state_d = FLUSH;
         FLUSH: if (timeout || (!rx_empty && is_term)) begin
            state_d  = ACK;
            status_d = ST_E;
         end
         ACK: if (!tx_full) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) to_d = '0;
   end
   // FIFO handshakes: pop in every consuming state, push once the TX FIFO has room
   always_comb begin
      rd_uart = key_reset && !rx_empty && state_q != ACK;
      wr_uart = key_reset && state_q == ACK && !tx_full;
      busy    = state_q != IDLE;
   end
   assign tx_data   = status_q;
   assign sseg_val  = sseg_q;
   assign bar_level = bar_q;
   assign warn      = warn_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized checks of the command parser against a line-level model
module tb_uart_cmd_parser;
   localparam int TO = 300;
   localparam logic [7:0] LF = 8'h0A, CR = 8'h0D;
   logic        clk = 1'b0, key_reset = 1'b1, rx_empty = 1'b1, tx_full = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rd_uart, wr_uart, warn, busy;
   logic [7:0]  tx_data;
   logic [15:0] sseg_val;
   logic [9:0]  bar_level;
   logic [7:0]  rxq[$];
   logic        pop_now = 1'b0, rand_tx = 1'b0;
   int          stall_pct = 0, checks = 0, errors = 0;
   string       got_s = "", exp_s = "";
   logic [15:0] exp_sseg = '0;
   logic [9:0]  exp_bar = '0;
   logic        exp_warn = 1'b0;

   uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .TO_W(9)) dut (
      .clk(clk), .key_reset(key_reset), .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
      .tx_full(tx_full), .wr_uart(wr_uart), .tx_data(tx_data), .sseg_val(sseg_val),
      .bar_level(bar_level), .warn(warn), .busy(busy)
   );

   always #5 clk = ~clk;

   // show-ahead RX FIFO model with optional random starvation and TX back-pressure
   always @(posedge clk) begin
      #1;
      if (pop_now && rxq.size() != 0) rxq.delete(0);
      rx_empty = rxq.size() == 0 || (stall_pct != 0 && $urandom_range(0, 99) < stall_pct);
      rx_data  = rxq.size() != 0 ? rxq[0] : 8'($urandom);
      if (rand_tx) tx_full = $urandom_range(0, 3) == 0;
   end

   // mid-cycle monitor: records pops and transmitted status bytes, flags handshake abuse
   always @(negedge clk) begin
      pop_now = rd_uart;
      if (wr_uart) got_s = $sformatf("%s%c", got_s, tx_data);
      if (rd_uart && rx_empty) begin
         errors++;
         $display("FAIL rd_while_empty: rd_uart=%b rx_empty=%b, required rd_uart=0", rd_uart, rx_empty);
      end
      if (wr_uart && tx_full) begin
         errors++;
         $display("FAIL wr_while_full: wr_uart=%b tx_full=%b, required wr_uart=0", wr_uart, tx_full);
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   function automatic bit is_hex_c(byte c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
   endfunction

   function automatic int hex_val(byte c);
      return c <= "9" ? c - 48 : c <= "F" ? c - 55 : c - 87;
   endfunction

   // whole-line semantics: one command letter, exactly its digit count, value in range
   function automatic void model_line(string s);
      int n, v;
      bit ok;
      if (s.len() == 0) return;
      n  = s[0] == "S" ? 4 : s[0] == "L" ? 2 : s[0] == "W" ? 1 : 0;
      ok = n != 0 && s.len() == n + 1;
      v  = 0;
      for (int i = 1; i < s.len(); i++)
         if (!is_hex_c(s[i])) ok = 0;
         else v = v * 16 + hex_val(s[i]);
      if (ok && s[0] == "L" && v > 10) ok = 0;
      if (ok && s[0] == "W" && v > 1) ok = 0;
      if (ok && s[0] == "S") exp_sseg = 16'(v);
      if (ok && s[0] == "L") exp_bar = 10'((1 << v) - 1);
      if (ok && s[0] == "W") exp_warn = v[0];
      exp_s = $sformatf("%s%s", exp_s, ok ? "K" : "E");
   endfunction

   function automatic byte rand_hex();
      int r = $urandom_range(0, 21);
      return byte'(r < 10 ? 48 + r : r < 16 ? 55 + r : 81 + r);
   endfunction

   // random line body: empty, bad command, bad digit, extra byte, or well-formed
   function automatic string rand_body();
      int  k   = $urandom_range(0, 9);
      int  ci  = $urandom_range(0, 2);
      int  n   = ci == 0 ? 4 : ci == 1 ? 2 : 1;
      int  bad = $urandom_range(1, n);
      byte c;
      string s;
      if (k == 0) return "";
      c = ci == 0 ? "S" : ci == 1 ? "L" : "W";
      if (k == 1) begin
         c = byte'($urandom_range(33, 126));
         while (c == "S" || c == "L" || c == "W") c = byte'($urandom_range(33, 126));
      end
      s = $sformatf("%c", c);
      for (int i = 1; i <= n; i++)
         s = $sformatf("%s%c", s, k == 2 && i == bad ? byte'($urandom_range(71, 90)) :
                                  ci == 1 && i == 1 && k > 5 ? byte'("0") :
                                  ci == 2 && k > 5 ? byte'($urandom_range(48, 49)) : rand_hex());
      if (k == 3) s = $sformatf("%s%c", s, rand_hex());
      return s;
   endfunction

   task automatic push_str(string s);
      for (int i = 0; i < s.len(); i++) rxq.push_back(s[i]);
   endtask

   task automatic send_line(string body, logic [7:0] term);
      push_str(body);
      rxq.push_back(term);
      model_line(body);
   endtask

   task automatic settle();
      int n = 0;
      while ((rxq.size() != 0 || busy) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (n >= 20000) begin
         errors++;
         $display("FAIL settle: rxq=%0d busy=%b after %0d cycles, required empty and idle", rxq.size(), busy, n);
      end
   endtask

   task automatic test_reset();
      #2 key_reset = 1'b0;
      #1;
      checks++;
      if ({sseg_val, bar_level, warn, rd_uart, wr_uart, tx_data, busy} !== 38'd0) begin
         errors++;
         $display("FAIL reset_async: sseg=%h bar=%h warn=%b rd=%b wr=%b tx=%h busy=%b, required all 0",
                  sseg_val, bar_level, warn, rd_uart, wr_uart, tx_data, busy);
      end
      repeat (3) @(negedge clk);
      key_reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({sseg_val, bar_level, warn, wr_uart, tx_data, busy} !== 37'd0) begin
         errors++;
         $display("FAIL reset_release: sseg=%h bar=%h warn=%b wr=%b tx=%h busy=%b, required all 0",
                  sseg_val, bar_level, warn, wr_uart, tx_data, busy);
      end
   endtask

   task automatic test_sseg();
      int n = 0;
      got_s = "";
      exp_s = "";
      send_line("S12AF", LF);
      while (!(rd_uart && rx_data == LF) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100 || sseg_val !== 16'h0000) begin
         errors++;
         $display("FAIL sseg_before: popped=%0d sseg=%h, required terminator pop with sseg 0000", n < 100, sseg_val);
      end
      @(negedge clk);
      checks++;
      if (sseg_val !== 16'h12AF || wr_uart !== 1'b1 || tx_data !== 8'h4B) begin
         errors++;
         $display("FAIL sseg_k: sseg=%h wr=%b tx=%h, required 12af 1 4b", sseg_val, wr_uart, tx_data);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || wr_uart !== 1'b0) begin
         errors++;
         $display("FAIL sseg_idle: busy=%b wr=%b, required 0 0", busy, wr_uart);
      end
      settle();
      checks++;
      if (got_s != exp_s || sseg_val !== exp_sseg) begin
         errors++;
         $display("FAIL sseg_resp: got %s sseg=%h, required %s %h", got_s, sseg_val, exp_s, exp_sseg);
      end
   endtask

   task automatic test_bar();
      got_s = "";
      exp_s = "";
      send_line("L0a", CR);
      settle();
      checks++;
      if (bar_level !== 10'h3FF || got_s != "K" || bar_level !== exp_bar) begin
         errors++;
         $display("FAIL bar_ten: bar=%h resp %s, required 3ff K", bar_level, got_s);
      end
      send_line("L0B", LF);
      settle();
      checks++;
      if (bar_level !== 10'h3FF || got_s != exp_s || tx_data !== 8'h45) begin
         errors++;
         $display("FAIL bar_eleven: bar=%h resp %s tx=%h, required 3ff %s 45", bar_level, got_s, tx_data, exp_s);
      end
   endtask

   task automatic test_warn();
      int n, bad = 0;
      got_s = "";
      exp_s = "";
      send_line("W1", LF);
      settle();
      checks++;
      if (warn !== 1'b1 || got_s != "K" || sseg_val !== exp_sseg || bar_level !== exp_bar) begin
         errors++;
         $display("FAIL warn_set: warn=%b resp %s sseg=%h bar=%h, required 1 K %h %h",
                  warn, got_s, sseg_val, bar_level, exp_sseg, exp_bar);
      end
      send_line("Wg", LF);
      settle();
      checks++;
      if (warn !== 1'b1 || got_s != exp_s) begin
         errors++;
         $display("FAIL warn_bad_digit: warn=%b resp %s, required 1 %s", warn, got_s, exp_s);
      end
      n = got_s.len();
      rxq.push_back(LF);
      rxq.push_back(CR);
      rxq.push_back(LF);
      repeat (10) begin
         @(negedge clk);
         if (busy || wr_uart) bad++;
      end
      checks++;
      if (bad != 0 || got_s.len() != n || rxq.size() != 0) begin
         errors++;
         $display("FAIL bare_terms: busy/wr cycles=%0d responses=%0d left=%0d, required 0 %0d 0",
                  bad, got_s.len(), rxq.size(), n);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      got_s = "";
      exp_s = "";
      push_str("S12");
      while (!(rd_uart && rx_data == "2") && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL timeout_pop: last digit popped=0, required 1");
      end
      @(negedge clk);
      n = 0;
      while (!wr_uart && n < TO + 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != TO || tx_data !== 8'h45) begin
         errors++;
         $display("FAIL timeout_e: status after %0d cycles tx=%h, required %0d 45", n, tx_data, TO);
      end
      exp_s = "E";
      settle();
      checks++;
      if (got_s != exp_s || sseg_val !== exp_sseg) begin
         errors++;
         $display("FAIL timeout_once: resp %s sseg=%h, required %s %h", got_s, sseg_val, exp_s, exp_sseg);
      end
      send_line("S0001", LF);
      settle();
      checks++;
      if (sseg_val !== 16'h0001 || got_s != exp_s) begin
         errors++;
         $display("FAIL timeout_recover: sseg=%h resp %s, required 0001 %s", sseg_val, got_s, exp_s);
      end
   endtask

   task automatic test_txfull();
      int n = 0, bad = 0;
      got_s = "";
      exp_s = "";
      tx_full = 1'b1;
      send_line("W0", LF);
      send_line("L03", LF);
      while (!(rd_uart && rx_data == LF) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      repeat (100) begin
         if (wr_uart || rd_uart) bad++;
         @(negedge clk);
      end
      checks++;
      if (n >= 100 || bad != 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL txfull_hold: wr/rd cycles=%0d busy=%b, required 0 1", bad, busy);
      end
      checks++;
      if (warn !== 1'b0 || got_s != "") begin
         errors++;
         $display("FAIL txfull_reg: warn=%b resp %s, required 0 and none", warn, got_s);
      end
      tx_full = 1'b0;
      settle();
      checks++;
      if (got_s != exp_s || bar_level !== 10'h007 || warn !== exp_warn) begin
         errors++;
         $display("FAIL txfull_drain: resp %s bar=%h warn=%b, required %s 007 %b", got_s, bar_level, warn, exp_s, exp_warn);
      end
   endtask

   task automatic test_midframe();
      int n = 0;
      got_s = "";
      exp_s = "";
      push_str("S9");
      while (rxq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || n >= 100) begin
         errors++;
         $display("FAIL midframe_busy: busy=%b, required 1", busy);
      end
      #2 key_reset = 1'b0;
      #1;
      checks++;
      if ({sseg_val, bar_level, warn, rd_uart, wr_uart, tx_data, busy} !== 38'd0) begin
         errors++;
         $display("FAIL midframe_reset: sseg=%h bar=%h warn=%b rd=%b wr=%b tx=%h busy=%b, required all 0",
                  sseg_val, bar_level, warn, rd_uart, wr_uart, tx_data, busy);
      end
      exp_sseg = '0;
      exp_bar  = '0;
      exp_warn = 1'b0;
      @(negedge clk);
      key_reset = 1'b1;
      send_line("S1234", LF);
      settle();
      checks++;
      if (got_s != exp_s || sseg_val !== 16'h1234 || bar_level !== 10'h000 || warn !== 1'b0) begin
         errors++;
         $display("FAIL midframe_next: resp %s sseg=%h bar=%h warn=%b, required %s 1234 000 0",
                  got_s, sseg_val, bar_level, warn, exp_s);
      end
   endtask

   task automatic test_random();
      stall_pct = 30;
      rand_tx   = 1'b1;
      for (int r = 0; r < 3; r++) begin
         got_s = "";
         exp_s = "";
         for (int i = 0; i < 25; i++) send_line(rand_body(), $urandom_range(0, 1) ? LF : CR);
         settle();
         checks++;
         if (got_s != exp_s) begin
            errors++;
            $display("FAIL random_resp round %0d: got %s, required %s", r, got_s, exp_s);
         end
         checks++;
         if ({sseg_val, bar_level, warn} !== {exp_sseg, exp_bar, exp_warn}) begin
            errors++;
            $display("FAIL random_regs round %0d: sseg=%h bar=%h warn=%b, required %h %h %b",
                     r, sseg_val, bar_level, warn, exp_sseg, exp_bar, exp_warn);
         end
      end
      stall_pct = 0;
      rand_tx   = 1'b0;
      tx_full   = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sseg();
      test_bar();
      test_warn();
      test_timeout();
      test_txfull();
      test_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
